aes_block_enc: RTL and testbench

AES_BLOCK_ENC -- requirements
Module: aes_block_enc

---
 rtl/aes_block_enc_pkg.sv | 34 +++
 rtl/aes_block_enc_sbox.sv | 11 +
 rtl/aes_block_enc.sv | 118 +++++++++++
 tb/tb_aes_block_enc.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/aes_block_enc_pkg.sv
// Shared AES-256 constants: S-box table, round count, block width and GF(2^8) xtime helper.
// Byte 0 of a block lives in bits [127:120] (FIPS-197 column-major order).
package aes_block_enc_pkg;

  localparam int NUM_ROUNDS = 14;
  localparam int BLOCK_W    = 128;

  typedef logic [BLOCK_W-1:0] block_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_block_enc_sbox.sv
// AES forward S-box: one byte in, one byte out, purely combinational table lookup.
module aes_sbox
  import aes_block_enc_pkg::*;
(
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);

  assign out_o = SBOX[in_i];

endmodule

// File: rtl/aes_block_enc.sv
// Iterative AES-256 encryptor fed with an external round-key stream; 14 edges load-to-result.
// Busy blocks new loads; define AES_BLOCK_ENC_VALID_EN to add a one-cycle outValid pulse.
module aes_block_enc
  import aes_block_enc_pkg::*;
(
  input  logic         inClk,
  input  logic         inRstN,
  input  logic [127:0] inKeyData0,
  input  logic [127:0] inKeyData1,
  input  logic         inDataWr,
  input  logic [127:0] inDataData,
  output logic [127:0] outData,
  output logic         outBusy
`ifdef AES_BLOCK_ENC_VALID_EN
  ,
  output logic         outValid
`endif
);

  localparam logic [3:0] LAST_CNT = 4'(NUM_ROUNDS - 1);

  block_t     state_q, state_d;
  block_t     data_q, data_d;
  logic [3:0] cnt_q, cnt_d;
  logic       busy_q, busy_d;

  block_t sub_a, sub_b, round_out, final_out;

  function automatic block_t shift_rows(input block_t b);
    block_t r;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        r[127-8*(row+4*c) -: 8] = b[127-8*(row+4*((c+row)%4)) -: 8];
      end
    end
    return r;
  endfunction

  function automatic block_t mix_columns(input block_t b);
    block_t     r;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = b[127-32*c -: 8];
      a1 = b[119-32*c -: 8];
      a2 = b[111-32*c -: 8];
      a3 = b[103-32*c -: 8];
      r[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      r[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      r[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      r[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return r;
  endfunction

  // Stage B feeds on the stage-A round result so the last cycle covers rounds 13 and 14.
  for (genvar i = 0; i < 16; i++) begin : g_sbox
    aes_sbox u_sbox_a (.in_i(state_q[127-8*i -: 8]),   .out_o(sub_a[127-8*i -: 8]));
    aes_sbox u_sbox_b (.in_i(round_out[127-8*i -: 8]), .out_o(sub_b[127-8*i -: 8]));
  end

  assign round_out = mix_columns(shift_rows(sub_a)) ^ inKeyData0;
  assign final_out = shift_rows(sub_b) ^ inKeyData1;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    if (!busy_q) begin
      if (inDataWr) begin
        state_d = inDataData ^ inKeyData0;
        cnt_d   = 4'd1;
        busy_d  = 1'b1;
      end
    end else if (cnt_q == LAST_CNT) begin
      data_d = final_out;
      cnt_d  = 4'd0;
      busy_d = 1'b0;
    end else begin
      state_d = round_out;
      cnt_d   = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge inClk or negedge inRstN) begin
    if (!inRstN) begin
      state_q <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign outData = data_q;
  assign outBusy = busy_q;

`ifdef AES_BLOCK_ENC_VALID_EN
  logic valid_q, valid_d;

  assign valid_d = busy_q && (cnt_q == LAST_CNT);

  always_ff @(posedge inClk or negedge inRstN) begin
    if (!inRstN) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
    end
  end

  assign outValid = valid_q;
`endif

endmodule

// File: tb/tb_aes_block_enc.sv
// Directed bench for aes_block_enc: FIPS-197 C.3 and all-zero vectors, ignored strobes,
// mid-run reset and back-to-back loads; round keys are expanded here from the cipher key.
module tb_aes_block_enc;
  import aes_block_enc_pkg::*;

  localparam logic [255:0] C3_KEY  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] C3_PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C3_CT   = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] ZERO_CT = 128'hdc95c078a2408989ad48a21492842087;

  logic         inClk;
  logic         inRstN;
  logic [127:0] inKeyData0;
  logic [127:0] inKeyData1;
  logic         inDataWr;
  logic [127:0] inDataData;
  logic [127:0] outData;
  logic         outBusy;
`ifdef AES_BLOCK_ENC_VALID_EN
  logic         outValid;
`endif

  logic [127:0] rk [15];
  int n_tests = 0;
  int n_fail  = 0;

  aes_block_enc dut (
    .inClk      (inClk),
    .inRstN     (inRstN),
    .inKeyData0 (inKeyData0),
    .inKeyData1 (inKeyData1),
    .inDataWr   (inDataWr),
    .inDataData (inDataData),
    .outData    (outData),
    .outBusy    (outBusy)
`ifdef AES_BLOCK_ENC_VALID_EN
    ,
    .outValid   (outValid)
`endif
  );

  initial inClk = 1'b0;
  always #5 inClk = ~inClk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  task automatic expand_key(input logic [255:0] key);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0};
      end else if (i % 8 == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-8] ^ t;
    end
    for (int r = 0; r < 15; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] junk();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Entered and left at #1 after a rising edge with outBusy low.
  task automatic encrypt(input string tag, input logic [127:0] pt, input logic [127:0] exp_ct,
                         input logic [127:0] prev_ct, input int pulse_a, input int pulse_b);
    inDataData = pt;
    inKeyData0 = rk[0];
    inKeyData1 = junk();
    inDataWr   = 1'b1;
    @(posedge inClk); #1;
    for (int r = 1; r <= 13; r++) begin
      check($sformatf("%s busy r%0d", tag, r), {127'd0, outBusy}, 128'd1);
      check($sformatf("%s hold r%0d", tag, r), outData, prev_ct);
`ifdef AES_BLOCK_ENC_VALID_EN
      check($sformatf("%s valid r%0d", tag, r), {127'd0, outValid}, 128'd0);
`endif
      inKeyData0 = rk[r];
      inKeyData1 = (r == 13) ? rk[14] : junk();
      inDataData = junk();
      inDataWr   = (r == pulse_a) || (r == pulse_b);
      @(posedge inClk); #1;
    end
    inDataWr = 1'b0;
    check({tag, " done busy"}, {127'd0, outBusy}, 128'd0);
    check({tag, " result"}, outData, exp_ct);
`ifdef AES_BLOCK_ENC_VALID_EN
    check({tag, " valid pulse"}, {127'd0, outValid}, 128'd1);
`endif
  endtask

  initial begin
    inRstN     = 1'b0;
    inKeyData0 = '0;
    inKeyData1 = '0;
    inDataWr   = 1'b0;
    inDataData = '0;
    #12;
    check("reset busy", {127'd0, outBusy}, 128'd0);
    check("reset data", outData, 128'd0);
    @(negedge inClk);
    inRstN = 1'b1;
    @(posedge inClk); #1;

    expand_key(C3_KEY);
    check("keyexp rk14", rk[14], 128'h24fc79ccbf0979e9371ac23c6d68de36);
    encrypt("c3", C3_PT, C3_CT, 128'd0, -1, -1);
    encrypt("c3 ign", C3_PT, C3_CT, C3_CT, 3, 9);
    encrypt("c3 ign last", C3_PT, C3_CT, C3_CT, 13, -1);
    @(posedge inClk); #1;
    check("no restart busy", {127'd0, outBusy}, 128'd0);

    expand_key(256'd0);
    encrypt("zero", 128'd0, ZERO_CT, C3_CT, -1, -1);
    expand_key(C3_KEY);
    encrypt("b2b", C3_PT, C3_CT, ZERO_CT, -1, -1);
    expand_key(256'd0);
    encrypt("b2b zero", 128'd0, ZERO_CT, C3_CT, -1, -1);

    // Abort during round cycle 7, then rerun C.3 from a clean start.
    expand_key(C3_KEY);
    inDataData = C3_PT;
    inKeyData0 = rk[0];
    inDataWr   = 1'b1;
    @(posedge inClk); #1;
    inDataWr = 1'b0;
    for (int r = 1; r <= 6; r++) begin
      inKeyData0 = rk[r];
      @(posedge inClk); #1;
    end
    check("pre-reset busy", {127'd0, outBusy}, 128'd1);
    #2 inRstN = 1'b0;
    #1;
    check("async reset busy", {127'd0, outBusy}, 128'd0);
    check("async reset data", outData, 128'd0);
    @(posedge inClk); #1;
    check("held reset data", outData, 128'd0);
    @(negedge inClk);
    inRstN = 1'b1;
    @(posedge inClk); #1;
    check("post-reset busy", {127'd0, outBusy}, 128'd0);
    encrypt("c3 after rst", C3_PT, C3_CT, 128'd0, -1, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
